// File: rtl/vram_pkg.sv
// Shared types and constants for the VRAM fetch arbiter and its tag slots.
package vram_pkg;

  localparam int VRAM_AW = 19;
  localparam int VRAM_DW = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WAIT = 2'd2,
    WR   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    TGT_SLOT1 = 2'd0,
    TGT_SLOT2 = 2'd1,
    TGT_CPU   = 2'd2
  } target_t;

  typedef struct packed {
    logic               valid;
    logic [VRAM_AW-1:0] addr;
  } tag_t;

endpackage

// File: rtl/vram_slot.sv
// One video fetch slot: the tag of the word it holds, the held word, and the
// stale flag that asks the arbiter for a refetch.
module vram_slot
  import vram_pkg::*;
(
  input  logic               clk_sys,
  input  logic               reset,
  input  logic [VRAM_AW-1:0] vram_addr,
  input  logic               fill,
  input  logic [VRAM_AW-1:0] fill_addr,
  input  logic [VRAM_DW-1:0] fill_data,
  input  logic               inval,
  input  logic [VRAM_AW-1:0] inval_addr,
  output logic               stale,
  output logic [VRAM_DW-1:0] dout
);

  tag_t tag;

  // Tag records the address actually fetched, so a mid-fetch address change
  // leaves the slot stale and triggers another fetch.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      tag  <= '0;
      dout <= '0;
    end else if (fill) begin
      tag  <= '{valid: 1'b1, addr: fill_addr};
      dout <= fill_data;
    end else if (inval && (tag.addr == inval_addr)) begin
      tag.valid <= 1'b0;
    end
  end

  assign stale = !tag.valid || (tag.addr != vram_addr);

endmodule

// File: rtl/vram_fetch_arbiter.sv
// Single-port VRAM responder: keeps two video fetch slots current and slips
// CPU byte reads/writes in between, video first.
//
//   state | meaning
//   IDLE  | arbitrate: slot1 stale, slot2 stale, cpu read, cpu write
//   RD    | read address on mem_addr, latency count loaded
//   WAIT  | counting down; at zero mem_rdata is valid and is delivered
//   WR    | one-cycle byte write with ack and slot invalidate
module vram_fetch_arbiter
  import vram_pkg::*;
#(
  parameter int READ_LATENCY = 2
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic [VRAM_AW-1:0] vram_addr1,
  input  logic [VRAM_AW-1:0] vram_addr2,
  output logic [VRAM_DW-1:0] vram_dout1,
  output logic [VRAM_DW-1:0] vram_dout2,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [VRAM_AW:0]   cpu_addr,
  input  logic [7:0]         cpu_wdata,
  output logic [7:0]         cpu_rdata,
  output logic               cpu_ack,
  output logic [VRAM_AW-1:0] mem_addr,
  output logic               mem_we,
  output logic [1:0]         mem_be,
  output logic [VRAM_DW-1:0] mem_wdata,
  input  logic [VRAM_DW-1:0] mem_rdata
);

  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LATENCY - 1);

  state_t             state, state_nxt;
  target_t            target, pick;
  logic [VRAM_AW-1:0] pick_addr;
  logic [CNT_W-1:0]   cnt;
  logic               lane_q;
  logic [7:0]         rdata_q;
  logic [7:0]         sel_byte;
  logic               stale1, stale2;
  logic               deliver, fill1, fill2, inval;

  always_ff @(posedge clk_sys) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (stale1 || stale2)  state_nxt = RD;
        else if (cpu_req)      state_nxt = cpu_we ? WR : RD;
      end
      RD:      state_nxt = WAIT;
      WAIT:    if (cnt == '0) state_nxt = IDLE;
      WR:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pick      = TGT_CPU;
    pick_addr = cpu_addr[VRAM_AW:1];
    if (stale1) begin
      pick      = TGT_SLOT1;
      pick_addr = vram_addr1;
    end else if (stale2) begin
      pick      = TGT_SLOT2;
      pick_addr = vram_addr2;
    end
  end

  // mem_addr doubles as the address snapshot for the access in flight.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      target   <= TGT_SLOT1;
      mem_addr <= '0;
      lane_q   <= 1'b0;
      cnt      <= '0;
      rdata_q  <= '0;
    end else begin
      if (state == IDLE && state_nxt != IDLE) begin
        target   <= pick;
        mem_addr <= pick_addr;
        lane_q   <= cpu_addr[0];
      end
      if (state == RD)                         cnt <= CNT_LOAD;
      else if (state == WAIT && cnt != '0)     cnt <= cnt - 1'b1;
      if (deliver && target == TGT_CPU)        rdata_q <= sel_byte;
    end
  end

  assign sel_byte  = lane_q ? mem_rdata[15:8] : mem_rdata[7:0];
  assign mem_wdata = {cpu_wdata, cpu_wdata};

  always_comb begin
    deliver   = (state == WAIT) && (cnt == '0);
    fill1     = deliver && (target == TGT_SLOT1);
    fill2     = deliver && (target == TGT_SLOT2);
    inval     = (state == WR);
    mem_we    = (state == WR);
    mem_be    = (state == WR) ? (lane_q ? 2'b10 : 2'b01) : 2'b00;
    cpu_ack   = (state == WR) || (deliver && target == TGT_CPU);
    cpu_rdata = (deliver && target == TGT_CPU) ? sel_byte : rdata_q;
  end

  vram_slot u_slot1 (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .vram_addr  (vram_addr1),
    .fill       (fill1),
    .fill_addr  (mem_addr),
    .fill_data  (mem_rdata),
    .inval      (inval),
    .inval_addr (mem_addr),
    .stale      (stale1),
    .dout       (vram_dout1)
  );

  vram_slot u_slot2 (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .vram_addr  (vram_addr2),
    .fill       (fill2),
    .fill_addr  (mem_addr),
    .fill_data  (mem_rdata),
    .inval      (inval),
    .inval_addr (mem_addr),
    .stale      (stale2),
    .dout       (vram_dout2)
  );

endmodule

// File: tb/tb_vram_fetch_arbiter.sv
// Directed bench for vram_fetch_arbiter with a small latency-modelled RAM.
module tb_vram_fetch_arbiter;
  localparam int L = 2;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [18:0] vram_addr1, vram_addr2;
  logic [15:0] vram_dout1, vram_dout2;
  logic        cpu_req, cpu_we;
  logic [19:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        cpu_ack;
  logic [18:0] mem_addr;
  logic        mem_we;
  logic [1:0]  mem_be;
  logic [15:0] mem_wdata, mem_rdata;

  int tests = 0;
  int failures = 0;
  int n;

  logic [15:0] ram [0:1023];
  logic [15:0] pipe [0:L-1];

  vram_fetch_arbiter #(.READ_LATENCY(L)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .vram_addr1(vram_addr1), .vram_addr2(vram_addr2),
    .vram_dout1(vram_dout1), .vram_dout2(vram_dout2),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic logic [15:0] ram_rd(input logic [18:0] a);
    return (a[18:10] == 9'd0) ? ram[a[9:0]] : 16'h0000;
  endfunction

  // Data for the address presented in cycle t is visible in cycle t+L.
  always @(posedge clk_sys) begin
    pipe[0] <= ram_rd(mem_addr);
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    if (mem_we && mem_addr[18:10] == 9'd0)
      ram[mem_addr[9:0]] <= {mem_be[1] ? mem_wdata[15:8] : ram[mem_addr[9:0]][15:8],
                             mem_be[0] ? mem_wdata[7:0]  : ram[mem_addr[9:0]][7:0]};
  end
  assign mem_rdata = pipe[L-1];

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input int budget, output int cycles);
    cycles = 0;
    while (cpu_ack !== 1'b1 && cycles < budget) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 16'h0000;
    for (int i = 0; i < L; i++) pipe[i] = 16'h0000;
    ram[0]     = 16'hBEEF;
    ram[10'h100] = 16'hA55A;
    ram[10'h120] = 16'h1234;

    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    vram_addr1 = '0; vram_addr2 = '0;
    tick(); tick();
    chk("rst_dout1", 32'(vram_dout1), 32'h0);
    chk("rst_dout2", 32'(vram_dout2), 32'h0);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 32'h0);
    chk("rst_cpu_ack", 32'(cpu_ack), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_be", 32'(mem_be), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);

    // Fill both slots after reset: slot1 lands in cycle 4, slot2 in cycle 8.
    vram_addr1 = 19'h00100; vram_addr2 = 19'h00120; reset = 1'b0;
    tick();
    chk("t1_mem_addr_slot1", 32'(mem_addr), 32'h100);
    tick(); tick();
    chk("t1_dout1_not_yet", 32'(vram_dout1), 32'h0);
    tick();
    chk("t1_dout1", 32'(vram_dout1), 32'hA55A);
    tick();
    chk("t1_mem_addr_slot2", 32'(mem_addr), 32'h120);
    repeat (4) tick();
    chk("t1_dout1_c9", 32'(vram_dout1), 32'hA55A);
    chk("t1_dout2_c9", 32'(vram_dout2), 32'h1234);
    repeat (5) begin
      tick();
      chk("t1_idle_mem_addr", 32'(mem_addr), 32'h120);
      chk("t1_idle_no_ack", 32'(cpu_ack), 32'h0);
    end

    // CPU read of the high byte of word 0x120.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 20'h00241;
    tick();
    chk("t2_mem_addr", 32'(mem_addr), 32'h120);
    tick();
    chk("t2_ack_early", 32'(cpu_ack), 32'h0);
    tick();
    chk("t2_ack", 32'(cpu_ack), 32'h1);
    chk("t2_rdata", 32'(cpu_rdata), 32'h12);
    chk("t2_dout1", 32'(vram_dout1), 32'hA55A);
    chk("t2_dout2", 32'(vram_dout2), 32'h1234);
    cpu_req = 1'b0;
    tick();
    chk("t2_ack_pulse", 32'(cpu_ack), 32'h0);
    chk("t2_rdata_held", 32'(cpu_rdata), 32'h12);

    // CPU write to the low byte of word 0x100 invalidates slot1.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 20'h00200; cpu_wdata = 8'h77;
    tick();
    chk("t3_mem_we", 32'(mem_we), 32'h1);
    chk("t3_mem_be", 32'(mem_be), 32'h1);
    chk("t3_mem_wdata", 32'(mem_wdata), 32'h7777);
    chk("t3_mem_addr", 32'(mem_addr), 32'h100);
    chk("t3_ack", 32'(cpu_ack), 32'h1);
    cpu_req = 1'b0; cpu_we = 1'b0;
    tick();
    chk("t3_we_pulse", 32'(mem_we), 32'h0);
    chk("t3_ack_pulse", 32'(cpu_ack), 32'h0);
    chk("t3_mem_addr_refetch", 32'(mem_addr), 32'h100);
    repeat (3) tick();
    chk("t3_dout1_held", 32'(vram_dout1), 32'hA55A);
    tick();
    chk("t3_dout1_refetched", 32'(vram_dout1), 32'hA577);
    chk("t3_dout2", 32'(vram_dout2), 32'h1234);

    // Address change and CPU read in the same cycle: the video fetch
    // (RD + 2 WAIT + next IDLE arbitration = 4 cycles) goes first.
    vram_addr1 = 19'h00120;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 20'h00200;
    wait_ack(12, n);
    chk("t4_ack_latency", 32'(n), 32'd7);
    chk("t4_rdata", 32'(cpu_rdata), 32'h77);
    chk("t4_dout1", 32'(vram_dout1), 32'h1234);
    cpu_req = 1'b0;
    tick();
    chk("t4_ack_pulse", 32'(cpu_ack), 32'h0);

    // Address changes one cycle into slot1's WAIT.
    vram_addr1 = 19'h00100;
    tick();
    chk("t5_mem_addr", 32'(mem_addr), 32'h100);
    tick(); tick();
    vram_addr1 = 19'h00120;
    tick();
    chk("t5_first_fetch", 32'(vram_dout1), 32'hA577);
    repeat (3) tick();
    chk("t5_hold", 32'(vram_dout1), 32'hA577);
    tick();
    chk("t5_second_fetch", 32'(vram_dout1), 32'h1234);

    // Reset while a CPU write is being arbitrated.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 20'h00241; cpu_wdata = 8'hFF;
    reset = 1'b1;
    tick();
    chk("t6_mem_we", 32'(mem_we), 32'h0);
    chk("t6_ack", 32'(cpu_ack), 32'h0);
    chk("t6_dout1", 32'(vram_dout1), 32'h0);
    chk("t6_dout2", 32'(vram_dout2), 32'h0);
    chk("t6_cpu_rdata", 32'(cpu_rdata), 32'h0);
    chk("t6_mem_addr", 32'(mem_addr), 32'h0);
    chk("t6_mem_be", 32'(mem_be), 32'h0);
    tick();
    chk("t6_mem_we_2", 32'(mem_we), 32'h0);
    chk("t6_ack_2", 32'(cpu_ack), 32'h0);
    cpu_req = 1'b0; cpu_we = 1'b0;
    vram_addr1 = 19'h00000; vram_addr2 = 19'h00120; reset = 1'b0;
    tick();
    chk("t6_mem_we_3", 32'(mem_we), 32'h0);
    repeat (3) tick();
    chk("t6_refetch_dout1", 32'(vram_dout1), 32'hBEEF);
    repeat (4) tick();
    chk("t6_refetch_dout2", 32'(vram_dout2), 32'h1234);
    chk("t6_ram_untouched", 32'(ram[10'h120]), 32'h1234);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
